// File: rtl/player_pkg.sv
// Shared definitions for the music player controller: FSM state encoding
// and the system clock rate.
package player_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int CLK_HZ = 50000000;

endpackage

// File: rtl/cmd_holdoff.sv
// Button command lockout: after an accepted command, further commands are
// refused for HOLDOFF cycles (including the accepting cycle).
module cmd_holdoff #(
    parameter int HOLDOFF = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    output logic ready
);
    import player_pkg::*;

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(HOLDOFF - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign ready = (cnt == '0);

endmodule

// File: rtl/player_ctrl.sv
// Play/pause/stop and song-selection controller with button holdoff and
// end-of-song auto-advance.
module player_ctrl #(
    parameter int NUM_SONGS = 4,
    parameter int HOLDOFF   = 5000000,
    parameter int LOOP      = 1,
    localparam int SEL_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             play_pulse,
    input  logic             stop_pulse,
    input  logic             next_pulse,
    input  logic             prev_pulse,
    input  logic             song_done,
    output logic [SEL_W-1:0] song_sel,
    output logic             playing,
    output logic             note_rst,
    output logic [1:0]       state_o
);
    import player_pkg::*;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SONGS - 1);

    state_t state;
    logic   ready;
    logic   accept;

    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        return (s == LAST) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] sel_dec(input logic [SEL_W-1:0] s);
        return (s == '0) ? LAST : s - 1'b1;
    endfunction

    // Any button pulse while unlocked is one accepted command; extra pulses drop.
    assign accept = ready & (stop_pulse | play_pulse | next_pulse | prev_pulse);

    cmd_holdoff #(.HOLDOFF(HOLDOFF)) u_holdoff (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .ready  (ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOP;
            song_sel <= '0;
            playing  <= 1'b0;
            note_rst <= 1'b0;
        end else begin
            note_rst <= 1'b0;
            if (accept) begin
                if (stop_pulse) begin
                    state    <= STOP;
                    playing  <= 1'b0;
                    note_rst <= 1'b1;
                end else if (play_pulse) begin
                    case (state)
                        STOP: begin
                            state    <= PLAY;
                            playing  <= 1'b1;
                            note_rst <= 1'b1;
                        end
                        PLAY: begin
                            state   <= PAUSE;
                            playing <= 1'b0;
                        end
                        default: begin
                            state   <= PLAY;
                            playing <= 1'b1;
                        end
                    endcase
                end else if (next_pulse) begin
                    song_sel <= sel_inc(song_sel);
                    note_rst <= 1'b1;
                end else begin
                    song_sel <= sel_dec(song_sel);
                    note_rst <= 1'b1;
                end
            end else if (song_done && state == PLAY) begin
                // Without looping, finishing the last song ends playback in place.
                if (LOOP == 0 && song_sel == LAST) begin
                    state    <= STOP;
                    playing  <= 1'b0;
                    note_rst <= 1'b1;
                end else begin
                    song_sel <= sel_inc(song_sel);
                    note_rst <= 1'b1;
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: two instances (LOOP=1 and LOOP=0) share stimulus and
// are checked every cycle against a timestamp-based behavioural model.
module tb_player_ctrl;

    localparam int N  = 4;
    localparam int HO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic play_pulse = 1'b0, stop_pulse = 1'b0, next_pulse = 1'b0, prev_pulse = 1'b0;
    logic song_done = 1'b0;

    logic [1:0] sel_a, sel_b, st_a, st_b;
    logic       pl_a, pl_b, nr_a, nr_b;

    int passed = 0;
    int total  = 0;

    // model: index 0 is the LOOP=1 instance, index 1 the LOOP=0 instance
    int m_state [2];
    int m_sel   [2];
    int m_nrst  [2];
    int m_last;
    int cyc;

    always #10 clk = ~clk;

    player_ctrl #(.NUM_SONGS(N), .HOLDOFF(HO), .LOOP(1)) dut_a (
        .clk(clk), .rst(rst), .play_pulse(play_pulse), .stop_pulse(stop_pulse),
        .next_pulse(next_pulse), .prev_pulse(prev_pulse), .song_done(song_done),
        .song_sel(sel_a), .playing(pl_a), .note_rst(nr_a), .state_o(st_a)
    );

    player_ctrl #(.NUM_SONGS(N), .HOLDOFF(HO), .LOOP(0)) dut_b (
        .clk(clk), .rst(rst), .play_pulse(play_pulse), .stop_pulse(stop_pulse),
        .next_pulse(next_pulse), .prev_pulse(prev_pulse), .song_done(song_done),
        .song_sel(sel_b), .playing(pl_b), .note_rst(nr_b), .state_o(st_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    // Behavioural reference: holdoff is "at least HO cycles since last accepted command".
    task automatic model_update(input bit r, st, pl, nx, pv, sd);
        bit acc;
        acc = !r && (st || pl || nx || pv) && (cyc - m_last >= HO);
        if (r) m_last = cyc - HO;
        else if (acc) m_last = cyc;
        for (int i = 0; i < 2; i++) begin
            m_nrst[i] = 0;
            if (r) begin
                m_state[i] = 0;
                m_sel[i]   = 0;
            end else if (acc) begin
                if (st) begin
                    m_state[i] = 0;
                    m_nrst[i]  = 1;
                end else if (pl) begin
                    if (m_state[i] == 0) begin
                        m_state[i] = 1;
                        m_nrst[i]  = 1;
                    end else m_state[i] = (m_state[i] == 1) ? 2 : 1;
                end else if (nx) begin
                    m_sel[i]  = (m_sel[i] + 1) % N;
                    m_nrst[i] = 1;
                end else begin
                    m_sel[i]  = (m_sel[i] + N - 1) % N;
                    m_nrst[i] = 1;
                end
            end else if (sd && m_state[i] == 1) begin
                m_nrst[i] = 1;
                if (i == 1 && m_sel[i] == N - 1) m_state[i] = 0;
                else m_sel[i] = (m_sel[i] + 1) % N;
            end
        end
    endtask

    task automatic compare_all();
        check("a_state",   {30'd0, st_a},  m_state[0]);
        check("a_sel",     {30'd0, sel_a}, m_sel[0]);
        check("a_playing", {31'd0, pl_a},  (m_state[0] == 1) ? 1 : 0);
        check("a_note_rst",{31'd0, nr_a},  m_nrst[0]);
        check("b_state",   {30'd0, st_b},  m_state[1]);
        check("b_sel",     {30'd0, sel_b}, m_sel[1]);
        check("b_playing", {31'd0, pl_b},  (m_state[1] == 1) ? 1 : 0);
        check("b_note_rst",{31'd0, nr_b},  m_nrst[1]);
    endtask

    task automatic step(input bit r, st, pl, nx, pv, sd);
        @(negedge clk);
        rst = r; stop_pulse = st; play_pulse = pl;
        next_pulse = nx; prev_pulse = pv; song_done = sd;
        @(posedge clk);
        model_update(r, st, pl, nx, pv, sd);
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc    = 0;
        m_last = -HO;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_sel[i] = 0; m_nrst[i] = 0;
        end

        // reset values
        do_reset();
        check("rst_state", {30'd0, st_a}, 0);
        check("rst_sel",   {30'd0, sel_a}, 0);
        check("rst_play",  {31'd0, pl_a}, 0);
        check("rst_nrst",  {31'd0, nr_a}, 0);

        // first play after reset
        step(0, 0, 1, 0, 0, 0);
        check("play_state", {30'd0, st_a}, 1);
        check("play_playing", {31'd0, pl_a}, 1);
        check("play_nrst", {31'd0, nr_a}, 1);
        check("play_sel", {30'd0, sel_a}, 0);
        check("model_play_state", m_state[0], 1);
        idle(1);
        check("play_nrst_drop", {31'd0, nr_a}, 0);
        idle(12);

        // holdoff: second next 5 cycles later dropped, third at +10 accepted
        step(0, 0, 0, 1, 0, 0);
        idle(4);
        step(0, 0, 0, 1, 0, 0);
        check("hold_sel1", {30'd0, sel_a}, 1);
        check("hold_nrst0", {31'd0, nr_a}, 0);
        idle(4);
        step(0, 0, 0, 1, 0, 0);
        check("hold_sel2", {30'd0, sel_a}, 2);
        check("model_hold_sel2", m_sel[0], 2);

        // prev wraps 0 -> 3, next wraps back
        do_reset();
        step(0, 0, 1, 0, 0, 0);
        idle(12);
        step(0, 0, 0, 0, 1, 0);
        check("prev_wrap_sel", {30'd0, sel_a}, 3);
        check("prev_nrst", {31'd0, nr_a}, 1);
        idle(1);
        check("prev_nrst_drop", {31'd0, nr_a}, 0);
        idle(8);
        step(0, 0, 0, 1, 0, 0);
        check("next_wrap_sel", {30'd0, sel_a}, 0);

        // song_done on the last song: LOOP=1 wraps, LOOP=0 stops
        idle(12);
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1);
        check("loop1_sel", {30'd0, sel_a}, 0);
        check("loop1_state", {30'd0, st_a}, 1);
        check("loop1_nrst", {31'd0, nr_a}, 1);
        check("loop0_sel", {30'd0, sel_b}, 3);
        check("loop0_state", {30'd0, st_b}, 0);
        check("loop0_nrst", {31'd0, nr_b}, 1);

        // stop + play + song_done together from PLAY
        do_reset();
        step(0, 0, 1, 0, 0, 0);
        idle(12);
        step(0, 0, 0, 1, 0, 0);
        idle(12);
        step(0, 1, 1, 0, 0, 1);
        check("combo_state", {30'd0, st_a}, 0);
        check("combo_sel", {30'd0, sel_a}, 1);
        check("combo_nrst", {31'd0, nr_a}, 1);
        idle(1);
        check("combo_nrst_drop", {31'd0, nr_a}, 0);

        // reset mid-holdoff, then immediate play is accepted
        do_reset();
        step(0, 0, 1, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0);
        check("midrst_state", {30'd0, st_a}, 0);
        check("midrst_playing", {31'd0, pl_a}, 0);
        check("midrst_nrst", {31'd0, nr_a}, 0);
        step(0, 0, 1, 0, 0, 0);
        check("postrst_play", {30'd0, st_a}, 1);
        check("postrst_nrst", {31'd0, nr_a}, 1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(299) == 0),
                 ($urandom_range(15) == 0), ($urandom_range(5) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(6) == 0),
                 ($urandom_range(7) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameter NUM_SONGS, default 4, number of selectable songs (2..16).
REQ-002 Parameter HOLDOFF, default 5000000, cycles of command lockout after an accepted button command (100 ms at 50 MHz).
REQ-003 Parameter LOOP, default 1: 1 means auto-advance wraps from the last song to song 0; 0 means playback stops after the last song.
REQ-004 Port clk, input, 1 bit: the block's single clock, 50 MHz.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port play_pulse, input, 1 bit: debounced one-cycle press pulse that toggles play and pause.
REQ-007 Port stop_pulse, input, 1 bit: debounced one-cycle press pulse that stops playback.
REQ-008 Port next_pulse, input, 1 bit: debounced one-cycle press pulse that selects the next song.
REQ-009 Port prev_pulse, input, 1 bit: debounced one-cycle press pulse that selects the previous song.
REQ-010 Port song_done, input, 1 bit: one-cycle pulse from the note sequencer marking the end of the current song.
REQ-011 Port song_sel, output, SEL_W = clog2(NUM_SONGS) bits: current song index.
REQ-012 Port playing, output, 1 bit: high while in PLAY.
REQ-013 Port note_rst, output, 1 bit: one-cycle pulse that restarts the sequencer at the start of song_sel.
REQ-014 Port state_o, output, 2 bits: state encoding, STOP=0, PLAY=1, PAUSE=2.

Function
REQ-015 The FSM shall have exactly three states, STOP, PLAY and PAUSE, and all outputs shall be registered.
REQ-016 A button command shall be accepted only when the holdoff counter is 0; an accepted command shall load the counter with HOLDOFF-1, and the counter shall then count down by 1 per cycle.
REQ-017 If several button pulses arrive in the same cycle, only one shall be accepted, by priority stop > play > next > prev; the others shall be dropped.
REQ-018 play: STOP->PLAY with note_rst; PLAY->PAUSE; PAUSE->PLAY without note_rst.
REQ-019 stop: any state->STOP with note_rst; song_sel unchanged.
REQ-020 next: song_sel+1, wrapping NUM_SONGS-1->0; note_rst pulsed; state unchanged.
REQ-021 prev: song_sel-1, wrapping 0->NUM_SONGS-1; note_rst pulsed; state unchanged.
REQ-022 song_done in PLAY shall behave as next (wrap) when LOOP=1.
REQ-023 With LOOP=0, song_done in PLAY on song NUM_SONGS-1 shall go to STOP with note_rst and leave song_sel unchanged; on any other song it shall behave as next.
REQ-024 song_done shall be ignored in STOP and PAUSE.
REQ-025 song_done shall neither be subject to holdoff nor restart the holdoff counter.
REQ-026 If song_done and an accepted command occur in the same cycle, the command shall win and song_done shall be dropped.
REQ-027 Outputs shall change one cycle after the input pulse, and note_rst shall be high for exactly that one cycle.
REQ-028 playing shall equal (state==PLAY), and state_o shall equal the state register.

Reset
REQ-029 While rst is high: state=STOP, song_sel=0, playing=0, note_rst=0, holdoff counter=0.
REQ-030 Reset asserted mid-holdoff or mid-song shall take effect on the next clock edge with no residual pulse.
REQ-031 The first button pulse after reset is released shall be accepted.

Structure
REQ-032 Shared package player_pkg shall hold the state encoding (STOP/PLAY/PAUSE) and CLK_HZ = 50000000.
REQ-033 The holdoff counter shall be a sub-module, cmd_holdoff, with ports clk, rst, accept (in) and ready (out); it shall be instantiated once.

Verification
REQ-034 Reset, then play_pulse -> 1 cycle later state_o=1, playing=1, note_rst high for 1 cycle, song_sel=0.
REQ-035 With HOLDOFF=10, in PLAY: next_pulse, then next_pulse 5 cycles later -> song_sel=1 only; a third next_pulse at +10 cycles -> song_sel=2.
REQ-036 NUM_SONGS=4, song_sel=0: prev_pulse -> song_sel=3, note_rst high for 1 cycle; then next_pulse after holdoff -> song_sel=0.
REQ-037 LOOP=0, song_sel=3, PLAY: song_done -> state_o=0, song_sel=3, note_rst high; LOOP=1 under the same stimulus -> song_sel=0, state_o=1.
REQ-038 stop_pulse, play_pulse and song_done all in one cycle from PLAY -> STOP, song_sel unchanged, one note_rst pulse.
REQ-039 rst asserted 3 cycles into holdoff -> all outputs at reset values; play_pulse on the first cycle after rst release -> accepted.
